// File: rtl/eth_rx_ctrl.sv
// RMII receive controller: preamble/SFD hunt, dibit-to-byte assembly, field latching and CRC-32 check.
// Optional destination address filter enabled by defining ETH_RX_ADDR_FILTER_EN.
module eth_rx_ctrl #(
   parameter int          pMIN_PREAMBLE_DIBITS = 8,
   parameter int          pMIN_FRAME_BYTES     = 64,
   parameter int          pMAX_FRAME_BYTES     = 1518,
   parameter logic [47:0] pMAC_ADDR            = 48'h020000000001
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        i_crs_dv,
   input  logic [1:0]  i_rxd,
   output logic [7:0]  o_byte,
   output logic        o_byte_vld,
   output logic        o_sof,
   output logic        o_eof,
   output logic        o_crc_ok,
   output logic        o_frame_err,
   output logic [2:0]  o_err_code,
   output logic [47:0] o_dest_addr,
   output logic [15:0] o_len_type
);

   // state     | meaning
   // IDLE      | waiting for carrier with a 01 dibit
   // PREAMBLE  | counting 01 dibits, waiting for 11 (SFD end)
   // DEST_ADDR | bytes 0..5
   // SRC_ADDR  | bytes 6..11
   // LEN_TYPE  | bytes 12..13
   // DATA      | payload, pad and FCS until carrier drops
   // DROP      | frame discarded, silent until carrier drops
   typedef enum logic [2:0] {IDLE, PREAMBLE, DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA, DROP} state_t;

`ifdef ETH_RX_ADDR_FILTER_EN
   localparam bit FILTER_EN = 1'b1;
`else
   localparam bit FILTER_EN = 1'b0;
`endif

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
   localparam logic [5:0]  MIN_PRE     = 6'(pMIN_PREAMBLE_DIBITS);
   localparam logic [10:0] MIN_BYTES   = 11'(pMIN_FRAME_BYTES);
   localparam logic [10:0] MAX_BYTES   = 11'(pMAX_FRAME_BYTES);
   localparam logic [2:0]  ERR_NONE = 3'd0, ERR_CRC = 3'd1, ERR_RUNT = 3'd2,
                           ERR_GIANT = 3'd3, ERR_ALIGN = 3'd4, ERR_ADDR = 3'd5;

   state_t      state, state_nx;
   logic [5:0]  pre_cnt, pre_cnt_nx;
   logic [1:0]  dibit_cnt, dibit_cnt_nx;
   logic [10:0] byte_cnt, byte_cnt_nx;
   logic [5:0]  sh, sh_nx;
   logic [31:0] crc, crc_nx;
   logic [39:0] fld, fld_nx;
   logic        armed, armed_nx;
   logic        addr_rej, addr_rej_nx;
   logic [7:0]  byte_new, byte_nx;
   logic [47:0] dest_new, dest_nx;
   logic [15:0] len_nx;
   logic        byte_vld_nx, sof_nx, eof_nx, crc_ok_nx;
   logic [2:0]  err_nx;

   function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 2; i++) begin
         if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
         else             r = r >> 1;
      end
      return r;
   endfunction

   assign byte_new = {i_rxd, sh};
   assign dest_new = {fld, byte_new};

   always_comb begin
      state_nx     = state;
      pre_cnt_nx   = pre_cnt;
      dibit_cnt_nx = dibit_cnt;
      byte_cnt_nx  = byte_cnt;
      sh_nx        = sh;
      crc_nx       = crc;
      fld_nx       = fld;
      // a new frame may only start once the carrier has been seen low
      armed_nx     = armed | ~i_crs_dv;
      addr_rej_nx  = 1'b0;
      byte_nx      = o_byte;
      byte_vld_nx  = 1'b0;
      sof_nx       = 1'b0;
      eof_nx       = 1'b0;
      crc_ok_nx    = 1'b0;
      err_nx       = ERR_NONE;
      dest_nx      = o_dest_addr;
      len_nx       = o_len_type;

      case (state)
         IDLE: begin
            if (armed && i_crs_dv && i_rxd == 2'b01) begin
               state_nx   = PREAMBLE;
               pre_cnt_nx = 6'd1;
            end
         end
         PREAMBLE: begin
            if (!i_crs_dv) begin
               state_nx = IDLE;
            end else if (i_rxd == 2'b01) begin
               if (pre_cnt != '1) pre_cnt_nx = pre_cnt + 6'd1;
            end else if (i_rxd == 2'b11 && pre_cnt >= MIN_PRE) begin
               state_nx     = DEST_ADDR;
               dibit_cnt_nx = '0;
               byte_cnt_nx  = '0;
               crc_nx       = '1;
            end else begin
               state_nx = DROP;
            end
         end
         DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA: begin
            if (!i_crs_dv) begin
               state_nx = IDLE;
               eof_nx   = 1'b1;
               if (dibit_cnt != 2'd0)      err_nx = ERR_ALIGN;
               else if (byte_cnt < MIN_BYTES) err_nx = ERR_RUNT;
               else if (crc != CRC_RESIDUE)   err_nx = ERR_CRC;
               else                           crc_ok_nx = 1'b1;
            end else begin
               crc_nx       = crc_dibit(crc, i_rxd);
               sh_nx        = byte_new[7:2];
               dibit_cnt_nx = dibit_cnt + 2'd1;
               if (dibit_cnt == 2'd3) begin
                  if (byte_cnt == MAX_BYTES) begin
                     state_nx = DROP;
                     eof_nx   = 1'b1;
                     err_nx   = ERR_GIANT;
                  end else begin
                     byte_nx     = byte_new;
                     byte_vld_nx = 1'b1;
                     sof_nx      = (byte_cnt == 11'd0);
                     if (byte_cnt != '1) byte_cnt_nx = byte_cnt + 11'd1;
                     fld_nx      = {fld[31:0], byte_new};
                     case (state)
                        DEST_ADDR: if (byte_cnt == 11'd5) begin
                           dest_nx  = dest_new;
                           state_nx = SRC_ADDR;
                           if (FILTER_EN && dest_new != pMAC_ADDR && dest_new != '1) begin
                              addr_rej_nx = 1'b1;
                              state_nx    = DROP;
                           end
                        end
                        SRC_ADDR: if (byte_cnt == 11'd11) state_nx = LEN_TYPE;
                        LEN_TYPE: if (byte_cnt == 11'd13) begin
                           len_nx   = {fld[7:0], byte_new};
                           state_nx = DATA;
                        end
                        default: ;
                     endcase
                  end
               end
            end
         end
         DROP: begin
            if (!i_crs_dv) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase

      // address reject reports one cycle after the last dest byte strobe
      if (addr_rej) begin
         eof_nx = 1'b1;
         err_nx = ERR_ADDR;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= IDLE;
         pre_cnt     <= '0;
         dibit_cnt   <= '0;
         byte_cnt    <= '0;
         sh          <= '0;
         crc         <= '1;
         fld         <= '0;
         armed       <= 1'b0;
         addr_rej    <= 1'b0;
         o_byte      <= '0;
         o_byte_vld  <= 1'b0;
         o_sof       <= 1'b0;
         o_eof       <= 1'b0;
         o_crc_ok    <= 1'b0;
         o_frame_err <= 1'b0;
         o_err_code  <= '0;
         o_dest_addr <= '0;
         o_len_type  <= '0;
      end else begin
         state       <= state_nx;
         pre_cnt     <= pre_cnt_nx;
         dibit_cnt   <= dibit_cnt_nx;
         byte_cnt    <= byte_cnt_nx;
         sh          <= sh_nx;
         crc         <= crc_nx;
         fld         <= fld_nx;
         armed       <= armed_nx;
         addr_rej    <= addr_rej_nx;
         o_byte      <= byte_nx;
         o_byte_vld  <= byte_vld_nx;
         o_sof       <= sof_nx;
         o_eof       <= eof_nx;
         o_crc_ok    <= crc_ok_nx;
         o_frame_err <= (err_nx != ERR_NONE);
         o_err_code  <= err_nx;
         o_dest_addr <= dest_nx;
         o_len_type  <= len_nx;
      end
   end

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Directed testbench for eth_rx_ctrl: good, CRC, runt, giant, max-length, preamble, align,
// reset, back-to-back and (with ETH_RX_ADDR_FILTER_EN) address-filter frames.
module tb_eth_rx_ctrl;

   localparam logic [47:0] MAC   = 48'h020000000001;
   localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        i_crs_dv = 1'b0;
   logic [1:0]  i_rxd = 2'b00;
   logic [7:0]  o_byte;
   logic        o_byte_vld, o_sof, o_eof, o_crc_ok, o_frame_err;
   logic [2:0]  o_err_code;
   logic [47:0] o_dest_addr;
   logic [15:0] o_len_type;

   eth_rx_ctrl dut (
      .Clk(Clk), .Rst(Rst), .i_crs_dv(i_crs_dv), .i_rxd(i_rxd),
      .o_byte(o_byte), .o_byte_vld(o_byte_vld), .o_sof(o_sof), .o_eof(o_eof),
      .o_crc_ok(o_crc_ok), .o_frame_err(o_frame_err), .o_err_code(o_err_code),
      .o_dest_addr(o_dest_addr), .o_len_type(o_len_type)
   );

   always #10 Clk = ~Clk;

   int n_cmp = 0;
   int n_mis = 0;

   // monitor
   logic [7:0] rx_bytes [0:8191];
   int n_vld = 0, n_sof = 0, n_eof = 0, coinc = 0, sof_idx = -1;
   logic [7:0] sof_byte;
   logic       eof_ok, eof_ferr;
   logic [2:0] eof_code;

   always @(negedge Clk) begin
      if (o_sof) begin
         n_sof++;
         sof_byte = o_byte;
         sof_idx  = n_vld;
         if (!o_byte_vld) coinc++;
      end
      if (o_byte_vld) begin
         if (n_vld < 8192) rx_bytes[n_vld] = o_byte;
         n_vld++;
      end
      if (o_eof) begin
         n_eof++;
         eof_ok   = o_crc_ok;
         eof_ferr = o_frame_err;
         eof_code = o_err_code;
         if (o_byte_vld) coinc++;
      end
   end

   // frame model
   logic [7:0] frm [0:1699];
   int b_vld, b_sof, b_eof, b_coinc;
   int d_vld, d_sof, d_eof, d_coinc;

   task automatic build(input logic [47:0] dest, input logic [15:0] lt, input int n);
      logic [31:0] c;
      logic [47:0] src;
      src = 48'h02000000000A;
      for (int i = 0; i < 6; i++) begin
         frm[i]     = dest[47-8*i -: 8];
         frm[6+i]   = src[47-8*i -: 8];
      end
      frm[12] = lt[15:8];
      frm[13] = lt[7:0];
      for (int i = 14; i < n - 4; i++) frm[i] = 8'(i * 7 + 3);
      c = 32'hFFFFFFFF;
      for (int i = 0; i < n - 4; i++) begin
         c = c ^ {24'h0, frm[i]};
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      c = ~c;
      for (int i = 0; i < 4; i++) frm[n-4+i] = c[8*i +: 8];
   endtask

   task automatic dibit(input logic dv, input logic [1:0] d);
      @(negedge Clk);
      i_crs_dv = dv;
      i_rxd    = d;
   endtask

   task automatic preamble(input int n);
      for (int i = 0; i < n; i++) dibit(1'b1, 2'b01);
      dibit(1'b1, 2'b11);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int k = 0; k < 4; k++) dibit(1'b1, b[2*k +: 2]);
   endtask

   task automatic send_bytes(input int from, input int to);
      for (int i = from; i < to; i++) send_byte(frm[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) dibit(1'b0, 2'b00);
   endtask

   task automatic snap;
      @(posedge Clk); #1;
      b_vld = n_vld; b_sof = n_sof; b_eof = n_eof; b_coinc = coinc;
   endtask

   task automatic deltas;
      @(posedge Clk); #1;
      d_vld = n_vld - b_vld; d_sof = n_sof - b_sof; d_eof = n_eof - b_eof; d_coinc = coinc - b_coinc;
   endtask

   task automatic frame(input int npre, input int nbytes, input int extra_dibits, input int gap);
      snap;
      preamble(npre);
      send_bytes(0, nbytes);
      for (int i = 0; i < extra_dibits; i++) dibit(1'b1, 2'b01);
      idle(gap);
      deltas;
   endtask

   task automatic test_reset;
      Rst = 1'b1;
      repeat (3) @(negedge Clk);
      n_cmp++; if ({o_byte_vld, o_sof, o_eof, o_crc_ok, o_frame_err} !== 5'b0) begin n_mis++; $display("FAIL reset_strobes: got %b want 00000", {o_byte_vld, o_sof, o_eof, o_crc_ok, o_frame_err}); end
      n_cmp++; if ({o_byte, o_err_code, o_dest_addr, o_len_type} !== 75'b0) begin n_mis++; $display("FAIL reset_data: byte %h code %0d dest %h lt %h want all 0", o_byte, o_err_code, o_dest_addr, o_len_type); end
      Rst = 1'b0;
      idle(4);
   endtask

   task automatic test_good;
      int bad;
      build(BCAST, 16'h0800, 64);
      frame(31, 64, 0, 8);
      bad = 0;
      for (int i = 0; i < 64; i++) if (rx_bytes[b_vld+i] !== frm[i]) bad++;
      n_cmp++; if (d_vld !== 64) begin n_mis++; $display("FAIL good_vld: got %0d want 64", d_vld); end
      n_cmp++; if (bad !== 0) begin n_mis++; $display("FAIL good_bytes: got %0d wrong bytes want 0", bad); end
      n_cmp++; if (d_sof !== 1 || sof_idx !== b_vld || sof_byte !== 8'hFF) begin n_mis++; $display("FAIL good_sof: got cnt %0d idx %0d byte %h want 1 %0d ff", d_sof, sof_idx, sof_byte, b_vld); end
      n_cmp++; if (d_eof !== 1) begin n_mis++; $display("FAIL good_eof: got %0d want 1", d_eof); end
      n_cmp++; if ({eof_ok, eof_ferr, eof_code} !== 5'b10_000) begin n_mis++; $display("FAIL good_status: got ok %b err %b code %0d want 1 0 0", eof_ok, eof_ferr, eof_code); end
      n_cmp++; if (o_len_type !== 16'h0800 || o_dest_addr !== BCAST) begin n_mis++; $display("FAIL good_fields: got lt %h dest %h want 0800 ffffffffffff", o_len_type, o_dest_addr); end
      n_cmp++; if (d_coinc !== 0) begin n_mis++; $display("FAIL good_strobe_overlap: got %0d want 0", d_coinc); end
   endtask

   task automatic test_crc;
      build(BCAST, 16'h0800, 64);
      frm[20] = frm[20] ^ 8'h10;
      frame(31, 64, 0, 8);
      n_cmp++; if (d_vld !== 64 || d_eof !== 1) begin n_mis++; $display("FAIL crc_counts: got vld %0d eof %0d want 64 1", d_vld, d_eof); end
      n_cmp++; if ({eof_ok, eof_ferr, eof_code} !== 5'b01_001) begin n_mis++; $display("FAIL crc_status: got ok %b err %b code %0d want 0 1 1", eof_ok, eof_ferr, eof_code); end
   endtask

   task automatic test_runt;
      build(MAC, 16'h0040, 60);
      frame(31, 60, 0, 8);
      n_cmp++; if (d_vld !== 60 || d_eof !== 1) begin n_mis++; $display("FAIL runt_counts: got vld %0d eof %0d want 60 1", d_vld, d_eof); end
      n_cmp++; if ({eof_ok, eof_ferr, eof_code} !== 5'b01_010) begin n_mis++; $display("FAIL runt_status: got ok %b err %b code %0d want 0 1 2", eof_ok, eof_ferr, eof_code); end
      n_cmp++; if (o_dest_addr !== MAC || o_len_type !== 16'h0040) begin n_mis++; $display("FAIL runt_fields: got dest %h lt %h want %h 0040", o_dest_addr, o_len_type, MAC); end
   endtask

   task automatic test_giant;
      int bad;
      build(BCAST, 16'h0800, 1600);
      frame(31, 1600, 0, 8);
      bad = 0;
      for (int i = 0; i < 1518; i++) if (rx_bytes[b_vld+i] !== frm[i]) bad++;
      n_cmp++; if (d_vld !== 1518) begin n_mis++; $display("FAIL giant_vld: got %0d want 1518", d_vld); end
      n_cmp++; if (bad !== 0) begin n_mis++; $display("FAIL giant_bytes: got %0d wrong want 0", bad); end
      n_cmp++; if (d_eof !== 1) begin n_mis++; $display("FAIL giant_eof: got %0d want 1", d_eof); end
      n_cmp++; if ({eof_ok, eof_ferr, eof_code} !== 5'b01_011) begin n_mis++; $display("FAIL giant_status: got ok %b err %b code %0d want 0 1 3", eof_ok, eof_ferr, eof_code); end
      n_cmp++; if (d_coinc !== 0) begin n_mis++; $display("FAIL giant_strobe_overlap: got %0d want 0", d_coinc); end
   endtask

   task automatic test_max_len;
      build(MAC, 16'h05DC, 1518);
      frame(8, 1518, 0, 8);
      n_cmp++; if (d_vld !== 1518 || d_eof !== 1) begin n_mis++; $display("FAIL max_counts: got vld %0d eof %0d want 1518 1", d_vld, d_eof); end
      n_cmp++; if ({eof_ok, eof_ferr, eof_code} !== 5'b10_000) begin n_mis++; $display("FAIL max_status: got ok %b err %b code %0d want 1 0 0", eof_ok, eof_ferr, eof_code); end
   endtask

   task automatic test_short_preamble;
      build(BCAST, 16'h0800, 64);
      frame(4, 64, 0, 8);
      n_cmp++; if (d_vld !== 0 || d_sof !== 0 || d_eof !== 0) begin n_mis++; $display("FAIL pre4_silent: got vld %0d sof %0d eof %0d want 0 0 0", d_vld, d_sof, d_eof); end
      frame(7, 64, 0, 8);
      n_cmp++; if (d_vld !== 0 || d_sof !== 0 || d_eof !== 0) begin n_mis++; $display("FAIL pre7_silent: got vld %0d sof %0d eof %0d want 0 0 0", d_vld, d_sof, d_eof); end
      frame(8, 64, 0, 8);
      n_cmp++; if (d_vld !== 64 || d_sof !== 1 || d_eof !== 1) begin n_mis++; $display("FAIL pre8_counts: got vld %0d sof %0d eof %0d want 64 1 1", d_vld, d_sof, d_eof); end
      n_cmp++; if ({eof_ok, eof_ferr, eof_code} !== 5'b10_000) begin n_mis++; $display("FAIL pre8_status: got ok %b err %b code %0d want 1 0 0", eof_ok, eof_ferr, eof_code); end
   endtask

   task automatic test_align;
      build(BCAST, 16'h0800, 70);
      frame(31, 70, 1, 8);
      n_cmp++; if (d_vld !== 70 || d_eof !== 1) begin n_mis++; $display("FAIL align_counts: got vld %0d eof %0d want 70 1", d_vld, d_eof); end
      n_cmp++; if ({eof_ok, eof_ferr, eof_code} !== 5'b01_100) begin n_mis++; $display("FAIL align_status: got ok %b err %b code %0d want 0 1 4", eof_ok, eof_ferr, eof_code); end
   endtask

   task automatic test_reset_mid;
      build(MAC, 16'h0800, 64);
      snap;
      preamble(31);
      send_bytes(0, 30);
      dibit(1'b1, frm[30][1:0]);
      Rst = 1'b1;
      dibit(1'b1, frm[30][3:2]);
      Rst = 1'b0;
      n_cmp++; if ({o_byte_vld, o_sof, o_eof, o_byte} !== 11'b0) begin n_mis++; $display("FAIL rstmid_out: got vld %b sof %b eof %b byte %h want 0", o_byte_vld, o_sof, o_eof, o_byte); end
      n_cmp++; if (o_dest_addr !== 48'h0 || o_len_type !== 16'h0) begin n_mis++; $display("FAIL rstmid_fields: got dest %h lt %h want 0 0", o_dest_addr, o_len_type); end
      // carrier still high: an embedded preamble+SFD must not start a frame
      for (int i = 0; i < 4; i++) send_byte(8'h55);
      send_byte(8'hD5);
      send_bytes(0, 20);
      idle(8);
      deltas;
      n_cmp++; if (d_vld !== 30 || d_eof !== 0) begin n_mis++; $display("FAIL rstmid_silent: got vld %0d eof %0d want 30 0", d_vld, d_eof); end
      frame(31, 64, 0, 8);
      n_cmp++; if (d_vld !== 64 || d_eof !== 1 || eof_code !== 3'd0 || eof_ok !== 1'b1) begin n_mis++; $display("FAIL rstmid_next: got vld %0d eof %0d code %0d ok %b want 64 1 0 1", d_vld, d_eof, eof_code, eof_ok); end
   endtask

   task automatic test_back_to_back;
      build(MAC, 16'h0806, 64);
      snap;
      preamble(8);
      send_bytes(0, 64);
      idle(1);
      preamble(8);
      send_bytes(0, 64);
      idle(8);
      deltas;
      n_cmp++; if (d_vld !== 128 || d_sof !== 2 || d_eof !== 2) begin n_mis++; $display("FAIL b2b_counts: got vld %0d sof %0d eof %0d want 128 2 2", d_vld, d_sof, d_eof); end
      n_cmp++; if ({eof_ok, eof_ferr, eof_code} !== 5'b10_000 || d_coinc !== 0) begin n_mis++; $display("FAIL b2b_status: got ok %b err %b code %0d overlap %0d want 1 0 0 0", eof_ok, eof_ferr, eof_code, d_coinc); end
   endtask

`ifdef ETH_RX_ADDR_FILTER_EN
   task automatic test_filter;
      build(48'h020000000002, 16'h0800, 64);
      frame(31, 64, 0, 8);
      n_cmp++; if (d_vld !== 6 || d_eof !== 1) begin n_mis++; $display("FAIL filt_counts: got vld %0d eof %0d want 6 1", d_vld, d_eof); end
      n_cmp++; if ({eof_ok, eof_ferr, eof_code} !== 5'b01_101) begin n_mis++; $display("FAIL filt_status: got ok %b err %b code %0d want 0 1 5", eof_ok, eof_ferr, eof_code); end
      n_cmp++; if (o_dest_addr !== 48'h020000000002 || d_coinc !== 0) begin n_mis++; $display("FAIL filt_dest: got %h overlap %0d want 020000000002 0", o_dest_addr, d_coinc); end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_good;
      test_crc;
      test_runt;
      test_giant;
      test_max_len;
      test_short_preamble;
      test_align;
      test_reset_mid;
      test_back_to_back;
`ifdef ETH_RX_ADDR_FILTER_EN
      test_filter;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
